direction_filter: RTL
=====================

DIRECTION_FILTER -- requirements
Module: direction_filter

Interface
REQ-001 Parameter MIN_LINES, default 8, minimum qualifying lines for a frame vote to count.
REQ-002 Parameter CONFIRM_FRAMES, default 3, consecutive identical frame votes needed to change the command.
REQ-003 Parameter LOST_FRAMES, default 5, consecutive empty frames before the block reports SEARCH.
REQ-004 Parameter CNT_W, default 9, width of the per-direction line tally counters.
REQ-005 clk  in  1  pixel clock shared with the classifier; the block uses this one clock only.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 HREF  in  1  line-active qualifier, same signal the classifier sees.
REQ-008 VSYNC  in  1  frame sync; a rising edge marks the frame boundary.
REQ-009 orangeDetected  in  1  classifier per-pixel orange flag.
REQ-010 direction  in  3  classifier code: 000 none, 001 left, 010 right, 011 center.
REQ-011 cmd  out  3  steering command: 000 stop, 001 left, 010 right, 011 center, 100 search.
REQ-012 cmd_valid  out  1  one-cycle pulse on every frame decision, whether or not cmd changed.
REQ-013 locked  out  1  high while the block is in state LOCKED.

Function
REQ-014 The block SHALL register HREF and VSYNC once, detecting HREF falling edges and VSYNC rising edges from the registered copies.
REQ-015 On an HREF falling edge with orangeDetected=1, it SHALL increment the tally for the sampled direction; codes 000 and 1xx SHALL be ignored.
REQ-016 Tallies SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-017 On a VSYNC rising edge, the frame vote SHALL be the direction with the largest tally if that tally is at least MIN_LINES, otherwise none.
REQ-018 Tally ties SHALL resolve with priority center > left > right.
REQ-019 Tallies SHALL clear on the clock edge that registers the frame vote.
REQ-020 If an HREF fall and a VSYNC rise are detected in the same cycle, that line SHALL count toward the closing frame.
REQ-021 The state machine SHALL have three states: SEARCH, ACQUIRE and LOCKED.
REQ-022 SEARCH transitions:
  - non-none vote -> ACQUIRE, candidate = vote, agree count = 1;
  - none vote -> stay.
REQ-023 ACQUIRE transitions:
  - vote equals candidate -> increment agree count; at CONFIRM_FRAMES go to LOCKED with cmd = candidate;
  - different non-none vote -> candidate = vote, agree count = 1;
  - none vote -> SEARCH.
REQ-024 LOCKED transitions:
  - vote equals cmd -> clear miss count;
  - different non-none vote -> ACQUIRE with that candidate, agree count = 1, cmd held;
  - none vote -> increment miss count; at LOST_FRAMES go to SEARCH with cmd = 100.
REQ-025 cmd SHALL change only in LOCKED entry or LOST_FRAMES expiry; cmd is stop until the first lock.
REQ-026 Latency: cmd, locked and cmd_valid SHALL update on the second rising clk edge after VSYNC is first sampled high.
REQ-027 Agree and miss counters SHALL saturate at their thresholds.

Reset
REQ-028 On reset_n low, outputs SHALL be cmd=000, cmd_valid=0, locked=0.
REQ-029 On reset_n low, state SHALL be SEARCH and all tallies, counters and edge registers SHALL be 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; the first VSYNC rise after release SHALL vote on lines seen since release only.

Structure
REQ-031 The direction/command enum (dir_t) and the state enum SHALL reside in shared package camera_pkg, which the classifier also uses.
REQ-032 Edge detection SHALL be a reusable sub-module, edge_detect, instantiated twice.

Verification
REQ-033 Stimulus: 3 frames, each with 20 lines tagged center. Response: cmd=011 and locked=1 after frame 3; cmd_valid pulses 3 times.
REQ-034 Stimulus: frame with left=7, right=0. Response: vote none, state stays SEARCH, cmd=000.
REQ-035 Stimulus: frame with left=12, center=12. Response: vote center.
REQ-036 Stimulus: LOCKED on left, then 5 empty frames. Response: cmd=100 and locked=0 after the 5th frame; cmd stays 001 through frames 1-4.
REQ-037 Stimulus: LOCKED on right, then a 2-frame center burst followed by right. Response: cmd stays 010 throughout, then relocks on right.
REQ-038 Stimulus: reset_n pulsed low mid-frame. Response: outputs cleared asynchronously; next vote reflects post-release lines only.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared camera-path types: classifier direction codes / steering commands, filter states,
// and the mapping from a direction code to its per-direction tally slot.
package camera_pkg;

  typedef enum logic [2:0] {
    DIR_NONE   = 3'b000,
    DIR_LEFT   = 3'b001,
    DIR_RIGHT  = 3'b010,
    DIR_CENTER = 3'b011,
    DIR_SEARCH = 3'b100
  } dir_t;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam int NUM_DIRS   = 3;
  localparam int IDX_LEFT   = 0;
  localparam int IDX_RIGHT  = 1;
  localparam int IDX_CENTER = 2;

  // Codes 000 and 1xx map to no slot at all.
  function automatic logic [NUM_DIRS-1:0] dir_onehot(input logic [2:0] code);
    logic [NUM_DIRS-1:0] oh;
    oh = '0;
    case (code)
      DIR_LEFT:   oh[IDX_LEFT]   = 1'b1;
      DIR_RIGHT:  oh[IDX_RIGHT]  = 1'b1;
      DIR_CENTER: oh[IDX_CENTER] = 1'b1;
      default:    oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a level once and flags one transition (rising or falling) from the registered copy.
// Latency: flag is high the cycle after the new level is first sampled; no backpressure.
module edge_detect #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic edge_o
);

  logic sig_q;
  logic sig_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q      <= 1'b0;
      sig_prev_q <= 1'b0;
    end else begin
      sig_q      <= sig_i;
      sig_prev_q <= sig_q;
    end
  end

  assign edge_o = RISING ? (sig_q & ~sig_prev_q) : (~sig_q & sig_prev_q);

endmodule

// File: rtl/direction_filter.sv
// Frame-level steering filter: tallies per-line classifier verdicts, votes once per frame, debounces into cmd.
// Latency: outputs update 2 clk after VSYNC is first sampled high; no backpressure (cmd_valid is a pulse).
module direction_filter
  import camera_pkg::*;
#(
  parameter int MIN_LINES      = 8,
  parameter int CONFIRM_FRAMES = 3,
  parameter int LOST_FRAMES    = 5,
  parameter int CNT_W          = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       HREF,
  input  logic       VSYNC,
  input  logic       orangeDetected,
  input  logic [2:0] direction,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic       locked
);

  localparam int AGREE_W = $clog2(CONFIRM_FRAMES + 1);
  localparam int MISS_W  = $clog2(LOST_FRAMES + 1);

  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   MIN_CNT    = CNT_W'(MIN_LINES);
  localparam logic [AGREE_W-1:0] AGREE_TGT  = AGREE_W'(CONFIRM_FRAMES);
  localparam logic [AGREE_W-1:0] AGREE_ONE  = AGREE_W'(1);
  localparam logic [MISS_W-1:0]  MISS_TGT   = MISS_W'(LOST_FRAMES);
  localparam logic [MISS_W-1:0]  MISS_ONE   = MISS_W'(1);

  logic href_fall;
  logic vs_rise;

  edge_detect #(.RISING(1'b0)) u_href_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_i   (HREF),
    .edge_o  (href_fall)
  );

  edge_detect #(.RISING(1'b1)) u_vsync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_i   (VSYNC),
    .edge_o  (vs_rise)
  );

  logic [NUM_DIRS-1:0] hit;
  logic [CNT_W-1:0]    tally_q   [NUM_DIRS];
  logic [CNT_W-1:0]    tally_nxt [NUM_DIRS];
  logic [CNT_W-1:0]    tally_d   [NUM_DIRS];

  assign hit = (href_fall && orangeDetected) ? dir_onehot(direction) : '0;

  // tally_nxt already includes a line ending in the same cycle as the frame boundary,
  // so that line is voted with the frame it belongs to.
  always_comb begin
    for (int i = 0; i < NUM_DIRS; i++) begin
      tally_nxt[i] = tally_q[i];
      if (hit[i] && (tally_q[i] != CNT_MAX)) begin
        tally_nxt[i] = tally_q[i] + CNT_ONE;
      end
      tally_d[i] = vs_rise ? '0 : tally_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIRS; i++) begin
        tally_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIRS; i++) begin
        tally_q[i] <= tally_d[i];
      end
    end
  end

  dir_t             best_dir;
  logic [CNT_W-1:0] best_cnt;
  dir_t             vote;

  // Strict '>' lets the earlier candidate keep a tie: center, then left, then right.
  always_comb begin
    best_dir = DIR_CENTER;
    best_cnt = tally_nxt[IDX_CENTER];
    if (tally_nxt[IDX_LEFT] > best_cnt) begin
      best_dir = DIR_LEFT;
      best_cnt = tally_nxt[IDX_LEFT];
    end
    if (tally_nxt[IDX_RIGHT] > best_cnt) begin
      best_dir = DIR_RIGHT;
      best_cnt = tally_nxt[IDX_RIGHT];
    end
    vote = (best_cnt >= MIN_CNT) ? best_dir : DIR_NONE;
  end

  state_t               state_q, state_d;
  dir_t                 cand_q, cand_d;
  dir_t                 cmd_q, cmd_d;
  logic [AGREE_W-1:0]   agree_q, agree_d, agree_inc;
  logic [MISS_W-1:0]    miss_q, miss_d, miss_inc;
  logic                 valid_q;

  assign agree_inc = (agree_q >= AGREE_TGT) ? AGREE_TGT : agree_q + AGREE_ONE;
  assign miss_inc  = (miss_q >= MISS_TGT) ? MISS_TGT : miss_q + MISS_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SEARCH;
      cand_q  <= DIR_NONE;
      cmd_q   <= DIR_NONE;
      agree_q <= '0;
      miss_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cmd_q   <= cmd_d;
      agree_q <= agree_d;
      miss_q  <= miss_d;
      valid_q <= vs_rise;
    end
  end

  // cmd only moves on lock entry or on loss of the target; ACQUIRE keeps the old command.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cmd_d   = cmd_q;
    agree_d = agree_q;
    miss_d  = miss_q;
    if (vs_rise) begin
      unique case (state_q)
        ST_SEARCH: begin
          if (vote != DIR_NONE) begin
            state_d = ST_ACQUIRE;
            cand_d  = vote;
            agree_d = AGREE_ONE;
          end
        end
        ST_ACQUIRE: begin
          if (vote == DIR_NONE) begin
            state_d = ST_SEARCH;
          end else if (vote == cand_q) begin
            agree_d = agree_inc;
            if (agree_inc >= AGREE_TGT) begin
              state_d = ST_LOCKED;
              cmd_d   = cand_q;
              miss_d  = '0;
            end
          end else begin
            cand_d  = vote;
            agree_d = AGREE_ONE;
          end
        end
        ST_LOCKED: begin
          if (vote == DIR_NONE) begin
            miss_d = miss_inc;
            if (miss_inc >= MISS_TGT) begin
              state_d = ST_SEARCH;
              cmd_d   = DIR_SEARCH;
            end
          end else if (vote == cmd_q) begin
            miss_d = '0;
          end else begin
            state_d = ST_ACQUIRE;
            cand_d  = vote;
            agree_d = AGREE_ONE;
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end
  end

  always_comb begin
    cmd       = cmd_q;
    cmd_valid = valid_q;
    locked    = (state_q == ST_LOCKED);
  end

endmodule
